// File: rtl/mult_fu_ctrl_pkg.sv
// Shared types for the multiply functional unit: op encoding, FSM states,
// ROB tag width and the 33-bit operand extension rules.
package mult_fu_ctrl_pkg;

    localparam int ROB_IDX_W_DEF = 5;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mult_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } fu_state_t;

    // rs1 is signed for everything except MULHU; rs2 only for MUL/MULH.
    function automatic logic [32:0] ext_a(input mult_op_t op, input logic [31:0] v);
        return {v[31] & (op != MULHU), v};
    endfunction

    function automatic logic [32:0] ext_b(input mult_op_t op, input logic [31:0] v);
        return {v[31] & ((op == MUL) || (op == MULH)), v};
    endfunction

endpackage

// File: rtl/mult_fu_ctrl_if.sv
// Issue/response bus between the reservation station / CDB and the multiply unit.
interface mult_fu_ctrl_if
    import mult_fu_ctrl_pkg::*;
#(
    parameter int ROB_IDX_W = ROB_IDX_W_DEF
);
    logic                 req_valid;
    logic                 req_ready;
    mult_op_t             req_op;
    logic [31:0]          req_rs1;
    logic [31:0]          req_rs2;
    logic [ROB_IDX_W-1:0] req_rob_idx;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [ROB_IDX_W-1:0] resp_rob_idx;
    logic [31:0]          resp_data;
    logic                 flush;
    logic                 busy;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_rob_idx, resp_ready, flush,
        input  req_ready, resp_valid, resp_rob_idx, resp_data, busy
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_rob_idx, resp_ready, flush,
        output req_ready, resp_valid, resp_rob_idx, resp_data, busy
    );
endinterface

// File: rtl/mult_fu_ctrl_mult.sv
// Sequential 33x33 multiplier: operands registered on start, product and
// complete registered NUM_CYC cycles later (NUM_CYC >= 2). complete stays high until the next start.
module mult_fu_ctrl_mult #(
    parameter int NUM_CYC = 3,
    parameter bit TC_MODE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        start,
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic        complete,
    output logic [65:0] product
);
    localparam int CNT_W = $clog2(NUM_CYC) + 1;

    logic [32:0]      a_reg, b_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             running_reg, complete_reg;
    logic [65:0]      product_reg;
    logic [65:0]      a_ext, b_ext, prod;

    assign a_ext = TC_MODE ? {{33{a_reg[32]}}, a_reg} : {33'b0, a_reg};
    assign b_ext = TC_MODE ? {{33{b_reg[32]}}, b_reg} : {33'b0, b_reg};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            cnt_reg      <= '0;
            running_reg  <= 1'b0;
            complete_reg <= 1'b0;
            product_reg  <= '0;
        end else if (start) begin
            a_reg        <= a;
            b_reg        <= b;
            cnt_reg      <= '0;
            running_reg  <= 1'b1;
            complete_reg <= 1'b0;
        end else if (!hold && running_reg) begin
            if (cnt_reg == CNT_W'(NUM_CYC - 2)) begin
                complete_reg <= 1'b1;
                running_reg  <= 1'b0;
                product_reg  <= prod;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign complete = complete_reg;
    assign product  = product_reg;
endmodule

// File: rtl/mult_fu_ctrl.sv
// Multiply functional-unit controller: accepts one op, sequences the shared
// multiplier, and holds the result on the CDB port until granted.
module mult_fu_ctrl
    import mult_fu_ctrl_pkg::*;
#(
    parameter int NUM_CYC   = 3,
    parameter int ROB_IDX_W = ROB_IDX_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    mult_fu_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_CYC + 2) + 1;

    fu_state_t            state_reg, state_next;
    mult_op_t             op_reg;
    logic [32:0]          a_reg, b_reg;
    logic [ROB_IDX_W-1:0] tag_reg;
    logic [31:0]          result_reg;
    logic [CNT_W-1:0]     cnt_reg;

    logic        req_ready_int, accept, mult_start, mult_complete;
    logic [65:0] product;
    logic        unused_prod_hi;

    assign unused_prod_hi = ^product[65:64];

    always_comb begin
        state_next    = state_reg;
        req_ready_int = 1'b0;
        mult_start    = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready_int = 1'b1;
                if (bus.req_valid) state_next = START;
            end
            START: begin
                mult_start = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                // cnt_reg >= 1 masks a complete level left over from the previous op
                if (mult_complete && (cnt_reg != '0)) state_next = DONE;
            end
            DONE: begin
                if (bus.resp_ready) begin
                    req_ready_int = 1'b1;
                    state_next    = bus.req_valid ? START : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) begin
            state_next    = IDLE;
            req_ready_int = 1'b0;
            mult_start    = 1'b0;
        end
    end

    assign accept = bus.req_valid & req_ready_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_reg     <= MUL;
            a_reg      <= '0;
            b_reg      <= '0;
            tag_reg    <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg  <= bus.req_op;
                a_reg   <= ext_a(bus.req_op, bus.req_rs1);
                b_reg   <= ext_b(bus.req_op, bus.req_rs2);
                tag_reg <= bus.req_rob_idx;
            end
            if (state_reg == START) begin
                cnt_reg <= '0;
            end else if (state_reg == BUSY && cnt_reg != {CNT_W{1'b1}}) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == BUSY && state_next == DONE) begin
                result_reg <= (op_reg == MUL) ? product[31:0] : product[63:32];
            end
        end
    end

    mult_fu_ctrl_mult #(
        .NUM_CYC (NUM_CYC),
        .TC_MODE (1'b1)
    ) DW_mult_seq_inst (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (1'b0),
        .start    (mult_start),
        .a        (a_reg),
        .b        (b_reg),
        .complete (mult_complete),
        .product  (product)
    );

    // req_ready is held low while reset is asserted so every output reads 0.
    assign bus.req_ready    = req_ready_int & rst_n;
    assign bus.resp_valid   = (state_reg == DONE);
    assign bus.resp_data    = result_reg;
    assign bus.resp_rob_idx = tag_reg;
    assign bus.busy         = (state_reg != IDLE);
endmodule
